// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one memory port.
// At most one read is outstanding; stores complete on grant.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       owner_q, owner_nxt;
  logic       fetch_win, data_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      owner_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      owner_q    <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    owner_nxt  = owner_q;
    fetch_win  = 1'b0;
    data_win   = 1'b0;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = 32'd0;
    d_rvalid   = 1'b0;
    d_rdata    = 32'd0;
    m_req      = 1'b0;
    m_we       = 1'b0;
    m_addr     = 32'd0;
    m_wdata    = 32'd0;
    m_be       = 4'd0;

    // Combinational outputs are gated so nothing leaks while reset is held.
    if (!reset) begin
      case (state)
        IDLE: begin
          fetch_win = i_req && (!d_req || starve_cnt == MAX_WAIT_C);
          data_win  = d_req && !fetch_win;
          if (fetch_win) begin
            m_req  = 1'b1;
            m_addr = i_addr;
            m_be   = 4'hf;
            i_gnt  = m_gnt;
          end else if (data_win) begin
            m_req   = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_be    = d_be;
            d_gnt   = m_gnt;
          end
          if (i_gnt) begin
            state_nxt = WAIT_I;
            owner_nxt = 1'b0;
          end else if (d_gnt) begin
            state_nxt = d_we ? IDLE : WAIT_D;
            owner_nxt = 1'b1;
          end
        end
        WAIT_I: begin
          if (m_rvalid) begin
            i_rvalid  = 1'b1;
            i_rdata   = m_rdata;
            state_nxt = IDLE;
          end
        end
        WAIT_D: begin
          if (m_rvalid) begin
            d_rvalid  = 1'b1;
            d_rdata   = m_rdata;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase

      // Starvation count only advances on IDLE cycles where fetch loses.
      if (!i_req || i_gnt)
        starve_nxt = 4'd0;
      else if (state == IDLE && starve_cnt < MAX_WAIT_C)
        starve_nxt = starve_cnt + 4'd1;
    end
  end

  assign busy  = (state == WAIT_I) || (state == WAIT_D);
  assign owner = owner_q;

endmodule
